alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single registered ALU between two requesters (e.g. the execute stage and the address/branch-compare path). It accepts one operation at a time through per-port valid/ready handshakes and grants round-robin. It drives the ALU operand/op/imm inputs from held registers, waits the ALU's one-clock result latency, and returns result plus flags on a single backpressured response port tagged with the requester id.

## Interface
- DSIZE, `DSIZE (16) from define.v — datapath width
- clk  in  1  — sole clock, rising edge
- rst  in  1  — synchronous, active-high reset
- req0_valid / req1_valid  in  1  — request present
- req0_ready / req1_ready  out  1  — request accepted this cycle
- req0_a / req1_a  in  DSIZE  — operand 1
- req0_b / req1_b  in  DSIZE  — operand 2
- req0_op / req1_op  in  3  — ALU opcode (`ADD, `SUB, `AND, OR=3'b011, `SLL, `RL, `SRL, `SRA)
- req0_imm / req1_imm  in  4  — shift amount
- rsp_valid  out  1  — response present
- rsp_ready  in  1  — consumer accepts response
- rsp_id  out  1  — 0 = requester 0, 1 = requester 1
- rsp_data  out  DSIZE  — ALU result
- rsp_flag  out  3  — ALU flags {Z, V, N}
- alu_data1, alu_data2  out  DSIZE  — to ALU Data1/Data2
- alu_op  out  3; alu_imm  out  4  — to ALU op/imm
- alu_out  in  DSIZE; alu_flag  in  3  — from ALU Out/flag

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: if any req*_valid, grant one; reqN_ready=1 for the granted port only (combinational, forced 0 while rst=1 or state≠IDLE); latch a, b, op, imm, id into operand registers; go to EXEC.
- EXEC: operand registers drive ALU; ALU registers result at end of cycle; go to CAPT.
- CAPT: capture alu_out → rsp_data, alu_flag → rsp_flag; go to RESP.
- RESP: rsp_valid=1; on rsp_valid && rsp_ready go to IDLE. rsp_* outputs are stable while stalled.
- Round-robin: last_grant register. Both valid → grant the port ≠ last_grant. One valid → grant it. last_grant updates on every grant.
- Operand registers hold their value through EXEC, CAPT, RESP and the following IDLE. The ALU output is never sampled except in CAPT.
- Flags pass through unmodified. For shift/rotate ops the ALU leaves its flags untouched, so rsp_flag carries the ALU's held flag value. Consumers must ignore rsp_flag for those ops.
- No new request is accepted before the current response handshake completes.

## Timing
- Reset (rst high at a rising edge): state=IDLE, last_grant=1 (req0 wins first contention), operand regs 0, alu_op=`ADD, alu_imm=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flag=0; req*_ready=0 while rst high.
- Latency: request handshake at cycle T → ALU edge at end of T+1 → capture at end of T+2 → rsp_valid high from T+3.
- Minimum issue interval: 4 cycles (handshake, EXEC, CAPT, RESP with rsp_ready=1; the next grant is made in IDLE the cycle after).
- Reset mid-operation (any state): the in-flight op is discarded and no response is issued. ALU internal flags are not reset by this block.
- Requester deasserting valid while not granted: legal, no effect. After ready, the request is consumed.

## Structure
- `DSIZE and opcode macros stay in define.v; FSM state encoding is local localparams (2-bit).
- One natural sub-module: rr_arb2 — 2-way round-robin grant with last_grant register and an update-enable input.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- After reset, req0: ADD a=0x7FFF b=0x0001 → req0_ready at T, rsp_valid at T+3, rsp_id=0, rsp_data=0x8000, rsp_flag[2:1]=2'b01.
- req1: SUB a=0x0005 b=0x0005 → rsp_id=1, rsp_data=0x0000, rsp_flag[2]=1, rsp_flag[1]=0.
- Both valid in the same cycle after reset (req0 AND 0xF0F0&0x0FF0, req1 SRA 0x8000 imm=3) → req0 granted first with rsp_data=0x00F0; req1 granted next with rsp_data=0xF000.
- Three back-to-back contended rounds → grants alternate 0,1,0. No port is granted twice in a row while the other is valid.
- rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_id, rsp_data and rsp_flag stay constant; both req*_ready stay 0; on the ready handshake → IDLE next cycle.
- rst asserted during CAPT → rsp_valid never rises for that op; state IDLE; a new req0 after reset completes with correct data at T+3.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: datapath width, ALU opcodes,
// FSM state encoding and the held-operand record.
package alu_arbiter_pkg;

    localparam int DSIZE = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_RL  = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Everything latched at grant time; it keeps driving the ALU until the next grant.
    typedef struct packed {
        logic             id;
        logic [DSIZE-1:0] a;
        logic [DSIZE-1:0] b;
        logic [2:0]       op;
        logic [3:0]       imm;
    } alu_req_t;

    localparam alu_req_t REQ_RESET = '{id: 1'b0, a: '0, b: '0, op: OP_ADD, imm: 4'd0};

    function automatic alu_req_t pack_req(input logic id, input logic [DSIZE-1:0] a,
                                          input logic [DSIZE-1:0] b, input logic [2:0] op,
                                          input logic [3:0] imm);
        alu_req_t r;
        r.id  = id;
        r.a   = a;
        r.b   = b;
        r.op  = op;
        r.imm = imm;
        return r;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: under contention the port that did not win last
// time is granted; a lone requester is always granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // Reset to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: round-robin grant, held
// operands through the ALU latency, and a backpressured tagged response.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DSIZE-1:0] req0_a,
    input  logic [DSIZE-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_imm,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DSIZE-1:0] req1_a,
    input  logic [DSIZE-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_imm,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [DSIZE-1:0] rsp_data,
    output logic [2:0]       rsp_flag,

    output logic [DSIZE-1:0] alu_data1,
    output logic [DSIZE-1:0] alu_data2,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_imm,
    input  logic [DSIZE-1:0] alu_out,
    input  logic [2:0]       alu_flag
);

    arb_state_t state;
    arb_state_t state_next;
    alu_req_t   opnd;
    alu_req_t   req_sel;
    logic [1:0] grant;
    logic       any_valid;
    logic       take;

    assign any_valid = req0_valid | req1_valid;
    assign take      = (state == ST_IDLE) && any_valid && !rst;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (take),
        .grant  (grant)
    );

    always_comb begin
        if (grant[1]) begin
            req_sel = pack_req(1'b1, req1_a, req1_b, req1_op, req1_imm);
        end else begin
            req_sel = pack_req(1'b0, req0_a, req0_b, req0_op, req0_imm);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_CAPT;
            ST_CAPT: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = take & grant[0];
        req1_ready = take & grant[1];
        rsp_valid  = (state == ST_RESP);
    end

    // Operands stay put until the next grant so the ALU keeps seeing a stable op.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd <= REQ_RESET;
        end else if (take) begin
            opnd <= req_sel;
        end
    end

    // The ALU output is only trusted one cycle after EXEC, i.e. in CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_flag <= 3'b000;
        end else if (state == ST_CAPT) begin
            rsp_data <= alu_out;
            rsp_flag <= alu_flag;
        end
    end

    assign rsp_id    = opnd.id;
    assign alu_data1 = opnd.a;
    assign alu_data2 = opnd.b;
    assign alu_op    = opnd.op;
    assign alu_imm   = opnd.imm;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU stands in for the real
// one, and expected responses come from an arithmetic reference of each opcode.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_imm = '0, req1_imm = '0;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_flag;
    logic [15:0] alu_data1, alu_data2;
    logic [2:0]  alu_op;
    logic [3:0]  alu_imm;
    logic [15:0] alu_out = '0;
    logic [2:0]  alu_flag = '0;

    int total = 0;
    int bad = 0;
    bit model_last;
    logic [15:0] rq_a [2];
    logic [15:0] rq_b [2];
    logic [2:0]  rq_op [2];
    logic [3:0]  rq_imm [2];

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_imm(req1_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op), .alu_imm(alu_imm),
        .alu_out(alu_out), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    function automatic bit is_shift(input logic [2:0] op);
        return op >= 3'b100;
    endfunction

    // Returns {Z, V, N, result}.
    function automatic logic [18:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] imm);
        logic [15:0] r;
        logic        v;
        logic [31:0] rot;
        v = 1'b0;
        rot = {a, a} << imm;
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a << imm;
            3'd5: r = rot[31:16];
            3'd6: r = a >> imm;
            default: r = 16'($signed(a) >>> imm);
        endcase
        return {(r == 16'h0000), v, r[15], r};
    endfunction

    // Behavioural registered ALU; shifts leave the flag register alone.
    always @(posedge clk) begin
        logic [18:0] res;
        res = alu_ref(alu_op, alu_data1, alu_data2, alu_imm);
        alu_out <= res[15:0];
        if (!is_shift(alu_op)) alu_flag <= res[18:16];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic v);
        if (p == 0) begin
            req0_valid = v; req0_a = rq_a[0]; req0_b = rq_b[0]; req0_op = rq_op[0]; req0_imm = rq_imm[0];
        end else begin
            req1_valid = v; req1_a = rq_a[1]; req1_b = rq_b[1]; req1_op = rq_op[1]; req1_imm = rq_imm[1];
        end
    endtask

    task automatic set_req(input int p, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [3:0] imm);
        rq_a[p] = a; rq_b[p] = b; rq_op[p] = op; rq_imm[p] = imm;
        drive_port(p, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Waits for a request handshake, checks the winner, and consumes that request.
    task automatic wait_grant(output int who);
        int exp;
        int n;
        exp = (req0_valid && req1_valid) ? (model_last ? 0 : 1) : (req0_valid ? 0 : 1);
        who = -1;
        n = 0;
        while (who < 0 && n < 20) begin
            #1;
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                total++;
                if (who != exp || (req0_ready && req1_ready)) begin
                    bad++;
                    $display("[TB] FAIL grant: ready0=%0b ready1=%0b, wanted port %0d", req0_ready, req1_ready, exp);
                end
            end else begin
                cyc();
                n++;
            end
        end
        if (who < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL grant_timeout: no ready within 20 cycles, wanted port %0d", exp);
        end else begin
            model_last = who[0];
            cyc();
            drive_port(who, 1'b0);
        end
    endtask

    // Called right after the request handshake edge; checks latency, payload and stall hold.
    task automatic check_rsp(input int p, input int stall);
        logic [18:0] exp;
        logic [15:0] cap_data;
        logic [2:0]  cap_flag;
        logic        cap_id;
        int n;
        exp = alu_ref(rq_op[p], rq_a[p], rq_b[p], rq_imm[p]);
        rsp_ready = (stall == 0);
        n = 1;
        while (!rsp_valid && n < 12) begin
            cyc();
            n++;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("[TB] FAIL latency: rsp_valid after %0d cycles, wanted 3", n);
        end
        if (!rsp_valid) return;
        total++;
        if (rsp_id !== p[0]) begin
            bad++;
            $display("[TB] FAIL rsp_id: got %0b wanted %0b", rsp_id, p[0]);
        end
        total++;
        if (rsp_data !== exp[15:0]) begin
            bad++;
            $display("[TB] FAIL rsp_data: op=%0d got %h wanted %h", rq_op[p], rsp_data, exp[15:0]);
        end
        if (!is_shift(rq_op[p])) begin
            total++;
            if (rsp_flag !== exp[18:16]) begin
                bad++;
                $display("[TB] FAIL rsp_flag: op=%0d got %b wanted %b", rq_op[p], rsp_flag, exp[18:16]);
            end
        end
        cap_data = rsp_data;
        cap_flag = rsp_flag;
        cap_id = rsp_id;
        for (int i = 0; i < stall; i++) begin
            cyc();
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== cap_data || rsp_flag !== cap_flag || rsp_id !== cap_id) begin
                bad++;
                $display("[TB] FAIL stall_hold: valid=%0b data=%h flag=%b id=%0b, wanted 1 %h %b %0b",
                         rsp_valid, rsp_data, rsp_flag, rsp_id, cap_data, cap_flag, cap_id);
            end
            total++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL busy_ready: ready0=%0b ready1=%0b wanted 0 0", req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        cyc();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rsp_release: rsp_valid=%0b after handshake, wanted 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rq_a[0] = 16'h1234; rq_b[0] = 16'h1111; rq_op[0] = 3'd0; rq_imm[0] = 4'd2;
        rq_a[1] = 16'h4321; rq_b[1] = 16'h2222; rq_op[1] = 3'd1; rq_imm[1] = 4'd5;
        drive_port(0, 1'b1);
        drive_port(1, 1'b1);
        cyc();
        cyc();
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready: ready0=%0b ready1=%0b wanted 0 0", req0_ready, req1_ready);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 16'h0 || rsp_flag !== 3'b0) begin
            bad++;
            $display("[TB] FAIL reset_rsp: valid=%0b id=%0b data=%h flag=%b wanted all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_flag);
        end
        total++;
        if (alu_data1 !== 16'h0 || alu_data2 !== 16'h0 || alu_op !== 3'b000 || alu_imm !== 4'h0) begin
            bad++;
            $display("[TB] FAIL reset_alu: d1=%h d2=%h op=%b imm=%h wanted all 0",
                     alu_data1, alu_data2, alu_op, alu_imm);
        end
        drive_port(0, 1'b0);
        drive_port(1, 1'b0);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_directed();
        int who;
        set_req(0, 16'h7FFF, 16'h0001, 3'd0, 4'd0);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
        set_req(1, 16'h0005, 16'h0005, 3'd1, 4'd0);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
    endtask

    task automatic test_contention();
        int who;
        do_reset();
        set_req(0, 16'hF0F0, 16'h0FF0, 3'd2, 4'd0);
        set_req(1, 16'h8000, 16'h0000, 3'd7, 4'd3);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
    endtask

    task automatic test_back_to_back();
        int who;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            set_req(0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
            set_req(1, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
            wait_grant(who);
            total++;
            if (who != r % 2) begin
                bad++;
                $display("[TB] FAIL alternate: round %0d granted %0d wanted %0d", r, who, r % 2);
            end
            if (who >= 0) check_rsp(who, 0);
        end
        drive_port(0, 1'b0);
        drive_port(1, 1'b0);
    endtask

    task automatic test_stall();
        int who;
        set_req(0, 16'h1357, 16'h2468, 3'd3, 4'd0);
        wait_grant(who);
        set_req(1, 16'h00FF, 16'h0001, 3'd0, 4'd0);
        if (who >= 0) check_rsp(who, 5);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
    endtask

    task automatic test_reset_in_capt();
        int who;
        bit seen;
        set_req(0, 16'hAAAA, 16'h1111, 3'd0, 4'd0);
        wait_grant(who);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_last = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen = 1'b1;
            cyc();
        end
        total++;
        if (seen || rsp_data !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_discard: rsp_valid seen=%0b data=%h, wanted 0 0000", seen, rsp_data);
        end
        set_req(0, 16'h0F00, 16'h00F0, 3'd0, 4'd0);
        wait_grant(who);
        if (who >= 0) check_rsp(who, 0);
    endtask

    task automatic test_random();
        int who;
        int pat;
        for (int k = 0; k < 24; k++) begin
            pat = $urandom_range(1, 3);
            if (pat[0]) set_req(0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
            if (pat[1]) set_req(1, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
            wait_grant(who);
            if (who >= 0) check_rsp(who, $urandom_range(0, 2));
            drive_port(0, 1'b0);
            drive_port(1, 1'b0);
        end
    endtask

    initial begin
        model_last = 1'b1;
        test_reset();
        test_directed();
        test_contention();
        test_back_to_back();
        test_stall();
        test_reset_in_capt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
